// File: rtl/alu_pkg.sv
// Shared ALU types for the rv32 execute path: opcode encoding, datapath width and
// the operand-slot record used by the issue queue.
package alu_pkg;

  localparam int ALU_W        = 32;
  localparam int IQ_TAG_MAX_W = 16;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_SLT  = 4'b0100,
    ALU_SLTU = 4'b0101,
    ALU_SLL  = 4'b0110,
    ALU_SRL  = 4'b0111,
    ALU_XOR  = 4'b1010,
    ALU_SRA  = 4'b1110,
    ALU_CNT  = 4'b1111
  } alu_op_e;

  // Tags are zero-extended into a fixed-width field so the record does not depend on TAG_W.
  typedef struct packed {
    logic                    rdy;
    logic [IQ_TAG_MAX_W-1:0] tag;
    logic [ALU_W-1:0]        data;
  } iq_operand_t;

endpackage

// File: rtl/alu_issue_queue_if.sv
// Dispatch, result-broadcast and issue signals of the ALU issue queue.
// slave = queue side, master = environment (dispatch, CDB, ALU) side.
interface alu_issue_queue_if #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 5
);
  import alu_pkg::*;

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             flush_i;
  logic             in_valid_i;
  logic             in_ready_o;
  logic [3:0]       in_op_i;
  logic             in_a_rdy_i;
  logic [ALU_W-1:0] in_a_i;
  logic [TAG_W-1:0] in_a_tag_i;
  logic             in_b_rdy_i;
  logic [ALU_W-1:0] in_b_i;
  logic [TAG_W-1:0] in_b_tag_i;
  logic [TAG_W-1:0] in_dst_tag_i;
  logic             cdb_valid_i;
  logic [TAG_W-1:0] cdb_tag_i;
  logic [ALU_W-1:0] cdb_data_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [3:0]       out_op_o;
  logic [ALU_W-1:0] out_a_o;
  logic [ALU_W-1:0] out_b_o;
  logic [TAG_W-1:0] out_dst_tag_o;
  logic [CNT_W-1:0] count_o;

  modport slave (
    input  flush_i, in_valid_i, in_op_i, in_a_rdy_i, in_a_i, in_a_tag_i,
           in_b_rdy_i, in_b_i, in_b_tag_i, in_dst_tag_i,
           cdb_valid_i, cdb_tag_i, cdb_data_i, out_ready_i,
    output in_ready_o, out_valid_o, out_op_o, out_a_o, out_b_o, out_dst_tag_o, count_o
  );

  modport master (
    output flush_i, in_valid_i, in_op_i, in_a_rdy_i, in_a_i, in_a_tag_i,
           in_b_rdy_i, in_b_i, in_b_tag_i, in_dst_tag_i,
           cdb_valid_i, cdb_tag_i, cdb_data_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_op_o, out_a_o, out_b_o, out_dst_tag_o, count_o
  );

endinterface

// File: rtl/alu_iq_operand.sv
// One operand slot of the ALU issue queue: dispatch load plus CDB tag-match wakeup.
// ALU_IQ_BYPASS_EN adds wake_o, the same-cycle match used for head bypass.
module alu_iq_operand
  import alu_pkg::*;
#(
  parameter int TAG_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             ld_rdy_i,
  input  logic [ALU_W-1:0] ld_data_i,
  input  logic [TAG_W-1:0] ld_tag_i,
  input  logic             cdb_valid_i,
  input  logic [TAG_W-1:0] cdb_tag_i,
  input  logic [ALU_W-1:0] cdb_data_i,
  output logic             rdy_o,
  output logic [ALU_W-1:0] data_o
`ifdef ALU_IQ_BYPASS_EN
  ,
  output logic             wake_o
`endif
);

  iq_operand_t             slot_q, slot_d;
  logic [IQ_TAG_MAX_W-1:0] ld_tag_ext, cdb_tag_ext;
  logic                    hit, ld_hit;

  assign ld_tag_ext  = IQ_TAG_MAX_W'(ld_tag_i);
  assign cdb_tag_ext = IQ_TAG_MAX_W'(cdb_tag_i);
  assign hit    = cdb_valid_i & ~slot_q.rdy & (slot_q.tag == cdb_tag_ext);
  // A broadcast racing the dispatch of its consumer must not be lost.
  assign ld_hit = cdb_valid_i & ~ld_rdy_i & (ld_tag_ext == cdb_tag_ext);

  always_comb begin
    slot_d = slot_q;
    if (load_i) begin
      slot_d.rdy  = ld_rdy_i | ld_hit;
      slot_d.tag  = ld_tag_ext;
      slot_d.data = ld_hit ? cdb_data_i : ld_data_i;
    end else if (hit) begin
      slot_d.rdy  = 1'b1;
      slot_d.data = cdb_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) slot_q.rdy <= 1'b0;
    else       slot_q.rdy <= slot_d.rdy;
    slot_q.tag  <= slot_d.tag;
    slot_q.data <= slot_d.data;
  end

  assign rdy_o  = slot_q.rdy;
  assign data_o = slot_q.data;
`ifdef ALU_IQ_BYPASS_EN
  assign wake_o = hit;
`endif

endmodule

// File: rtl/alu_issue_queue.sv
// In-order ALU issue queue: buffers dispatched micro-ops, wakes pending operands from the
// CDB and presents the head op to the ALU. ALU_IQ_BYPASS_EN enables same-cycle CDB issue.
module alu_issue_queue
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 5
) (
  input  logic          clk_i,
  input  logic          rst_i,
  alu_issue_queue_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DEPTH-1:0] vld_q, vld_d;
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  alu_op_e          op_q [DEPTH];
  alu_op_e          op_d [DEPTH];
  logic [TAG_W-1:0] dst_q [DEPTH];
  logic [TAG_W-1:0] dst_d [DEPTH];

  logic [DEPTH-1:0] a_rdy, b_rdy, load;
  logic [ALU_W-1:0] a_data [DEPTH];
  logic [ALU_W-1:0] b_data [DEPTH];
  logic             full, enq, deq, a_ok, b_ok;

  assign full = (count_q == CNT_W'(DEPTH));
  assign enq  = bus.in_valid_i & ~full;
  assign deq  = bus.out_valid_o & bus.out_ready_i;

  always_comb begin
    load = '0;
    if (enq && !bus.flush_i) load[tail_q] = 1'b1;
  end

`ifdef ALU_IQ_BYPASS_EN
  logic [DEPTH-1:0] a_wake, b_wake;
`endif

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    alu_iq_operand #(.TAG_W(TAG_W)) u_a (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .load_i      (load[i]),
      .ld_rdy_i    (bus.in_a_rdy_i),
      .ld_data_i   (bus.in_a_i),
      .ld_tag_i    (bus.in_a_tag_i),
      .cdb_valid_i (bus.cdb_valid_i),
      .cdb_tag_i   (bus.cdb_tag_i),
      .cdb_data_i  (bus.cdb_data_i),
      .rdy_o       (a_rdy[i]),
      .data_o      (a_data[i])
`ifdef ALU_IQ_BYPASS_EN
      ,
      .wake_o      (a_wake[i])
`endif
    );
    alu_iq_operand #(.TAG_W(TAG_W)) u_b (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .load_i      (load[i]),
      .ld_rdy_i    (bus.in_b_rdy_i),
      .ld_data_i   (bus.in_b_i),
      .ld_tag_i    (bus.in_b_tag_i),
      .cdb_valid_i (bus.cdb_valid_i),
      .cdb_tag_i   (bus.cdb_tag_i),
      .cdb_data_i  (bus.cdb_data_i),
      .rdy_o       (b_rdy[i]),
      .data_o      (b_data[i])
`ifdef ALU_IQ_BYPASS_EN
      ,
      .wake_o      (b_wake[i])
`endif
    );
  end

  // Head mux; with bypass a head operand matching the live broadcast takes the CDB value.
`ifdef ALU_IQ_BYPASS_EN
  assign a_ok        = a_rdy[head_q] | a_wake[head_q];
  assign b_ok        = b_rdy[head_q] | b_wake[head_q];
  assign bus.out_a_o = a_wake[head_q] ? bus.cdb_data_i : a_data[head_q];
  assign bus.out_b_o = b_wake[head_q] ? bus.cdb_data_i : b_data[head_q];
`else
  assign a_ok        = a_rdy[head_q];
  assign b_ok        = b_rdy[head_q];
  assign bus.out_a_o = a_data[head_q];
  assign bus.out_b_o = b_data[head_q];
`endif

  assign bus.out_valid_o   = vld_q[head_q] & a_ok & b_ok;
  assign bus.out_op_o      = op_q[head_q];
  assign bus.out_dst_tag_o = dst_q[head_q];
  assign bus.in_ready_o    = ~full;
  assign bus.count_o       = count_q;

  always_comb begin
    vld_d   = vld_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    op_d    = op_q;
    dst_d   = dst_q;
    if (bus.flush_i) begin
      // Collapse to empty at the current head so the pointers stay consistent with count.
      vld_d   = '0;
      count_d = '0;
      tail_d  = head_q;
    end else begin
      if (deq) begin
        vld_d[head_q] = 1'b0;
        head_d        = head_q + PTR_W'(1);
      end
      if (enq) begin
        vld_d[tail_q] = 1'b1;
        op_d[tail_q]  = alu_op_e'(bus.in_op_i);
        dst_d[tail_q] = bus.in_dst_tag_i;
        tail_d        = tail_q + PTR_W'(1);
      end
      case ({enq, deq})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      vld_q   <= vld_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
    op_q  <= op_d;
    dst_q <= dst_d;
  end

endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed self-checking bench for alu_issue_queue (expectations follow ALU_IQ_BYPASS_EN).
module tb_alu_issue_queue;

`ifdef ALU_IQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  alu_issue_queue_if #(.DEPTH(4), .TAG_W(5)) bus ();

  alu_issue_queue #(.DEPTH(4), .TAG_W(5)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle();
    bus.in_valid_i  = 1'b0;
    bus.cdb_valid_i = 1'b0;
    bus.flush_i     = 1'b0;
  endtask

  task automatic drive_op(input logic [3:0] op, input logic ar, input logic [31:0] a,
                          input logic [4:0] at, input logic br, input logic [31:0] b,
                          input logic [4:0] bt, input logic [4:0] dst);
    bus.in_valid_i   = 1'b1;
    bus.in_op_i      = op;
    bus.in_a_rdy_i   = ar;
    bus.in_a_i       = a;
    bus.in_a_tag_i   = at;
    bus.in_b_rdy_i   = br;
    bus.in_b_i       = b;
    bus.in_b_tag_i   = bt;
    bus.in_dst_tag_i = dst;
  endtask

  task automatic cdb(input logic [4:0] t, input logic [31:0] d);
    bus.cdb_valid_i = 1'b1;
    bus.cdb_tag_i   = t;
    bus.cdb_data_i  = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    drive_op(4'h0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 5'd0, 5'd0);
    bus.in_valid_i  = 1'b0;
    bus.cdb_tag_i   = '0;
    bus.cdb_data_i  = '0;
    bus.out_ready_i = 1'b0;

    // reset
    cyc(); cyc();
    rst = 1'b0;
    smp();
    chk("rst_count", 32'(bus.count_o), 0);
    chk("rst_valid", 32'(bus.out_valid_o), 0);
    chk("rst_ready", 32'(bus.in_ready_o), 1);

    // 1: both ready, issue next cycle
    drive_op(4'h0, 1'b1, 32'd5, 5'd0, 1'b1, 32'd7, 5'd0, 5'd3);
    cyc(); idle();
    smp();
    chk("t1_valid", 32'(bus.out_valid_o), 1);
    chk("t1_a", bus.out_a_o, 5);
    chk("t1_b", bus.out_b_o, 7);
    chk("t1_dst", 32'(bus.out_dst_tag_o), 3);
    chk("t1_count", 32'(bus.count_o), 1);
    bus.out_ready_i = 1'b1;
    cyc();
    bus.out_ready_i = 1'b0;
    smp();
    chk("t1_count_after", 32'(bus.count_o), 0);
    chk("t1_valid_after", 32'(bus.out_valid_o), 0);

    // 2: A pending on tag 9, broadcast two cycles later
    drive_op(4'h1, 1'b0, 32'h0, 5'd9, 1'b1, 32'd1, 5'd0, 5'd4);
    cyc(); idle();
    smp();
    chk("t2_wait_valid", 32'(bus.out_valid_o), 0);
    chk("t2_count", 32'(bus.count_o), 1);
    cyc();
    cdb(5'd9, 32'h100);
    smp();
    chk("t2_bcast_valid", 32'(bus.out_valid_o), 32'(BYP));
    if (BYP) chk("t2_bypass_a", bus.out_a_o, 32'h100);
    cyc(); idle();
    smp();
    chk("t2_valid", 32'(bus.out_valid_o), 1);
    chk("t2_a", bus.out_a_o, 32'h100);
    chk("t2_b", bus.out_b_o, 1);
    bus.out_ready_i = 1'b1;
    cyc();
    bus.out_ready_i = 1'b0;
    smp();
    chk("t2_count_after", 32'(bus.count_o), 0);

    // 3: fill, refuse fifth, drain in order across the wrap
    for (int i = 0; i < 4; i++) begin
      drive_op((i == 3) ? 4'hF : 4'(i + 2), 1'b1, 32'(16 + i), 5'd0,
               1'b1, 32'(32 + i), 5'd0, 5'(10 + i));
      cyc();
    end
    drive_op(4'h1, 1'b1, 32'hDEAD, 5'd0, 1'b1, 32'hBEEF, 5'd0, 5'd31);
    smp();
    chk("t3_full_ready", 32'(bus.in_ready_o), 0);
    chk("t3_full_count", 32'(bus.count_o), 4);
    cyc(); idle();
    smp();
    chk("t3_count_5th", 32'(bus.count_o), 4);
    chk("t3_head_stall", bus.out_a_o, 32'h10);
    bus.out_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t3_drain_valid", 32'(bus.out_valid_o), 1);
      chk("t3_drain_a", bus.out_a_o, 32'(16 + i));
      chk("t3_drain_b", bus.out_b_o, 32'(32 + i));
      chk("t3_drain_op", 32'(bus.out_op_o), (i == 3) ? 32'hF : 32'(i + 2));
      chk("t3_drain_dst", 32'(bus.out_dst_tag_o), 32'(10 + i));
      cyc(); smp();
    end
    chk("t3_empty_count", 32'(bus.count_o), 0);
    chk("t3_empty_valid", 32'(bus.out_valid_o), 0);
    bus.out_ready_i = 1'b0;

    // 4: dispatch/broadcast race
    drive_op(4'h2, 1'b0, 32'h0, 5'd2, 1'b1, 32'd3, 5'd0, 5'd7);
    cdb(5'd2, 32'hAA);
    cyc(); idle();
    smp();
    chk("t4_valid", 32'(bus.out_valid_o), 1);
    chk("t4_a", bus.out_a_o, 32'hAA);
    chk("t4_b", bus.out_b_o, 3);
    bus.out_ready_i = 1'b1;
    cyc();
    bus.out_ready_i = 1'b0;
    smp();
    chk("t4_count_after", 32'(bus.count_o), 0);

    // 5: in-order blocking behind pending head
    drive_op(4'h0, 1'b0, 32'h0, 5'd6, 1'b1, 32'h1, 5'd0, 5'd20);
    cyc();
    drive_op(4'h1, 1'b1, 32'h55, 5'd0, 1'b1, 32'h2, 5'd0, 5'd21);
    cyc(); idle();
    bus.out_ready_i = 1'b1;
    smp();
    chk("t5_block_valid", 32'(bus.out_valid_o), 0);
    chk("t5_block_count", 32'(bus.count_o), 2);
    cyc(); smp();
    chk("t5_block_valid2", 32'(bus.out_valid_o), 0);
    chk("t5_block_count2", 32'(bus.count_o), 2);
    cyc();
    cdb(5'd6, 32'h66);
    smp();
    if (BYP) begin
      chk("t5_byp_valid", 32'(bus.out_valid_o), 1);
      chk("t5_byp_a", bus.out_a_o, 32'h66);
      chk("t5_byp_dst", 32'(bus.out_dst_tag_o), 20);
    end else begin
      chk("t5_bcast_valid", 32'(bus.out_valid_o), 0);
      cyc(); idle();
      smp();
      chk("t5_x_valid", 32'(bus.out_valid_o), 1);
      chk("t5_x_a", bus.out_a_o, 32'h66);
      chk("t5_x_dst", 32'(bus.out_dst_tag_o), 20);
    end
    cyc(); idle();
    smp();
    chk("t5_y_valid", 32'(bus.out_valid_o), 1);
    chk("t5_y_a", bus.out_a_o, 32'h55);
    chk("t5_y_dst", 32'(bus.out_dst_tag_o), 21);
    cyc();
    bus.out_ready_i = 1'b0;
    smp();
    chk("t5_count_after", 32'(bus.count_o), 0);

    // 6: flush beats a same-cycle enqueue
    for (int i = 0; i < 3; i++) begin
      drive_op(4'h0, 1'b1, 32'(48 + i), 5'd0, 1'b1, 32'h0, 5'd0, 5'd1);
      cyc();
    end
    idle();
    smp();
    chk("t6_count3", 32'(bus.count_o), 3);
    bus.flush_i = 1'b1;
    drive_op(4'h0, 1'b1, 32'hBEEF, 5'd0, 1'b1, 32'h0, 5'd0, 5'd2);
    cyc(); idle();
    smp();
    chk("t6_flush_count", 32'(bus.count_o), 0);
    chk("t6_flush_valid", 32'(bus.out_valid_o), 0);
    chk("t6_flush_ready", 32'(bus.in_ready_o), 1);
    cyc(); smp();
    chk("t6_discard_count", 32'(bus.count_o), 0);
    chk("t6_discard_valid", 32'(bus.out_valid_o), 0);
    drive_op(4'h3, 1'b1, 32'h77, 5'd0, 1'b1, 32'h78, 5'd0, 5'd5);
    cyc(); idle();
    smp();
    chk("t6_post_valid", 32'(bus.out_valid_o), 1);
    chk("t6_post_a", bus.out_a_o, 32'h77);
    chk("t6_post_count", 32'(bus.count_o), 1);

    // mid-operation reset, then A and B woken by one broadcast
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    smp();
    chk("rst2_count", 32'(bus.count_o), 0);
    chk("rst2_valid", 32'(bus.out_valid_o), 0);
    drive_op(4'h5, 1'b0, 32'h0, 5'd7, 1'b0, 32'h0, 5'd7, 5'd9);
    cyc(); idle();
    cdb(5'd7, 32'h99);
    smp();
    chk("t7_bcast_valid", 32'(bus.out_valid_o), 32'(BYP));
    cyc(); idle();
    smp();
    chk("t7_valid", 32'(bus.out_valid_o), 1);
    chk("t7_a", bus.out_a_o, 32'h99);
    chk("t7_b", bus.out_b_o, 32'h99);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
